uart_autobaud_ctrl: RTL and testbench

UART_AUTOBAUD_CTRL -- requirements
Module: uart_autobaud_ctrl

---
 rtl/uart_autobaud_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_uart_autobaud_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl
// ------------------
// Measures the bit rate of an incoming 0x55 sync character and turns the
// measurement into the half-period-minus-one divisors that the tx baud
// counter and the rx oversample counter expect. Software can also load the
// divisors directly, which always overrides any measurement in progress.
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   rst          asynchronous active-high reset
//   rx_in        raw UART line (asynchronous to clk, idle high)
//   start        one-cycle pulse that arms autobaud detection
//   cfg_wr       one-cycle pulse that loads cfg_tx / cfg_rx
//   cfg_tx       manual tx divisor
//   cfg_rx       manual rx divisor
//   max_rate_tx  tx half-period-minus-one divisor
//   max_rate_rx  rx oversample half-period-minus-one divisor
//   busy         high while waiting for or measuring the sync character
//   locked       divisors come from a good measurement or a manual load
//   err          sticky flag for a failed measurement (too fast or timeout)

module uart_autobaud_ctrl #(
    parameter logic [31:0] DEFAULT_TX     = 32'd325,
    parameter logic [31:0] DEFAULT_RX     = 32'd20,
    parameter int          RX_OS_LOG2     = 4,
    parameter logic [31:0] MIN_BIT_CYCLES = 32'd64,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_in,
    input  logic        start,
    input  logic        cfg_wr,
    input  logic [31:0] cfg_tx,
    input  logic [31:0] cfg_rx,
    output logic [31:0] max_rate_tx,
    output logic [31:0] max_rate_rx,
    output logic        busy,
    output logic        locked,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        APPLY
    } stateT;

    stateT       state;
    stateT       stateNext;

    logic        rxSync1;
    logic        rxSync2;
    logic        rxPrev;
    logic        fallEdge;

    logic [31:0] cycleCnt;
    logic [31:0] intervalCnt;
    logic [2:0]  edgeCnt;
    logic [31:0] bitCycles;

    logic        armStart;
    logic        beginMeasure;
    logic        edgeHit;
    logic        lastEdge;
    logic        timeout;

    // The line is asynchronous, so it goes through two flops before anything
    // looks at it. A third flop keeps the previous synced value so a falling
    // edge is a simple one-cycle compare. All three sit at the idle level
    // (high) out of reset so reset release never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
            rxPrev  <= 1'b1;
        end else begin
            rxSync1 <= rx_in;
            rxSync2 <= rxSync1;
            rxPrev  <= rxSync2;
        end
    end

    assign fallEdge = rxPrev & ~rxSync2;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic plus the one-cycle strobes that steer the datapath.
    // A manual load beats everything, including a start in the same cycle,
    // and drops the FSM back to IDLE. A line that is already low when the
    // FSM arms produces no falling edge, so ARMED naturally waits for a
    // full high-then-low transition. An edge arriving on the same cycle the
    // interval would expire still counts as an edge.
    always_comb begin
        stateNext    = state;
        armStart     = 1'b0;
        beginMeasure = 1'b0;
        edgeHit      = 1'b0;
        lastEdge     = 1'b0;
        timeout      = 1'b0;
        busy         = (state == ARMED) || (state == MEASURE);

        if (cfg_wr) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stateNext = ARMED;
                        armStart  = 1'b1;
                    end
                end
                ARMED: begin
                    if (fallEdge) begin
                        stateNext    = MEASURE;
                        beginMeasure = 1'b1;
                    end
                end
                MEASURE: begin
                    if (fallEdge) begin
                        edgeHit = 1'b1;
                        if (edgeCnt == 3'd4) begin
                            lastEdge  = 1'b1;
                            stateNext = APPLY;
                        end
                    end else if (intervalCnt == TIMEOUT_CYCLES - 32'd1) begin
                        timeout   = 1'b1;
                        stateNext = IDLE;
                    end
                end
                APPLY: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // Measurement counters. The cycle counter spans from the start-bit edge
    // to the fifth edge (the start of d7), i.e. eight bit times, so the
    // captured total divided by eight is the bit period in clk cycles. Only
    // that quotient is kept; the low three bits never matter downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCnt    <= 32'd0;
            intervalCnt <= 32'd0;
            edgeCnt     <= 3'd0;
            bitCycles   <= 32'd0;
        end else if (beginMeasure) begin
            cycleCnt    <= 32'd0;
            intervalCnt <= 32'd0;
            edgeCnt     <= 3'd1;
        end else if (state == MEASURE) begin
            cycleCnt <= cycleCnt + 32'd1;
            if (edgeHit) begin
                intervalCnt <= 32'd0;
                edgeCnt     <= edgeCnt + 3'd1;
            end else begin
                intervalCnt <= intervalCnt + 32'd1;
            end
            if (lastEdge) begin
                bitCycles <= (cycleCnt + 32'd1) >> 3;
            end
        end
    end

    // Divisors and status flags. The divisors move only on a manual load or
    // while leaving APPLY, so downstream baud counters never see a value
    // from a half-finished measurement. A bit period shorter than the
    // minimum is rejected and leaves the previous divisors in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_rate_tx <= DEFAULT_TX;
            max_rate_rx <= DEFAULT_RX;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else if (cfg_wr) begin
            max_rate_tx <= cfg_tx;
            max_rate_rx <= cfg_rx;
            locked      <= 1'b1;
            err         <= 1'b0;
        end else begin
            if (armStart) begin
                locked <= 1'b0;
                err    <= 1'b0;
            end
            if (timeout) begin
                err <= 1'b1;
            end
            if (state == APPLY) begin
                if (bitCycles < MIN_BIT_CYCLES) begin
                    err <= 1'b1;
                end else begin
                    max_rate_tx <= (bitCycles >> 1) - 32'd1;
                    max_rate_rx <= (bitCycles >> (RX_OS_LOG2 + 1)) - 32'd1;
                    locked      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// tb_uart_autobaud_ctrl
// ---------------------
// Self-checking bench for uart_autobaud_ctrl. A short table of sync-character
// bit periods with hand-worked divisors comes first, then hand-written
// sequences for the timeout, manual-load and reset corner cases, then random
// bit periods checked against a small arithmetic model of the expected
// divisors and flags.

module tb_uart_autobaud_ctrl;

    localparam int TIMEOUT = 1000;

    logic        clk;
    logic        rst;
    logic        rx_in;
    logic        start;
    logic        cfg_wr;
    logic [31:0] cfg_tx;
    logic [31:0] cfg_rx;
    logic [31:0] max_rate_tx;
    logic [31:0] max_rate_rx;
    logic        busy;
    logic        locked;
    logic        err;

    int checkCount;
    int errorCount;

    logic [31:0] modelTx;
    logic [31:0] modelRx;
    logic        modelLocked;
    logic        modelErr;

    typedef struct {
        int          period;
        logic [31:0] expTx;
        logic [31:0] expRx;
        logic        expLocked;
        logic        expErr;
    } vecT;

    vecT vecs[6];

    uart_autobaud_ctrl #(
        .TIMEOUT_CYCLES(32'd1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_in),
        .start(start),
        .cfg_wr(cfg_wr),
        .cfg_tx(cfg_tx),
        .cfg_rx(cfg_rx),
        .max_rate_tx(max_rate_tx),
        .max_rate_rx(max_rate_rx),
        .busy(busy),
        .locked(locked),
        .err(err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison; prints a FAIL line on mismatch.
    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Samples every output on the next falling edge and compares it.
    task automatic checkOutput(input string name, input logic [31:0] expTx, input logic [31:0] expRx,
                               input logic expLocked, input logic expErr, input logic expBusy);
        @(negedge clk);
        checkValue({name, ".tx"}, max_rate_tx, expTx);
        checkValue({name, ".rx"}, max_rate_rx, expRx);
        checkValue({name, ".locked"}, {31'd0, locked}, {31'd0, expLocked});
        checkValue({name, ".err"}, {31'd0, err}, {31'd0, expErr});
        checkValue({name, ".busy"}, {31'd0, busy}, {31'd0, expBusy});
    endtask

    // Arithmetic view of a measurement of a perfectly clean 0x55 at the
    // given bit period: eight bit times between first and fifth falling
    // edge, a half-bit tx divisor and a 1/32-bit rx divisor.
    task automatic modelMeasure(input int period);
        int total;
        int bitPer;
        total       = 8 * period;
        bitPer      = total / 8;
        modelLocked = 1'b0;
        modelErr    = 1'b0;
        if (bitPer < 64) begin
            modelErr = 1'b1;
        end else begin
            modelTx     = bitPer / 2 - 1;
            modelRx     = bitPer / 32 - 1;
            modelLocked = 1'b1;
        end
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Sends one 8N1 frame, LSB first; entered and left 1 unit after a posedge.
    task automatic sendByte(input int period, input logic [7:0] data);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = frame[i];
            repeat (period) @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for busy to drop; an expired bound is a failed check.
    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkCount++;
        if (busy) begin
            errorCount++;
            $display("[TB] FAIL %s.idle: got busy=1 expected busy=0 within %0d cycles", name, budget);
        end
    endtask

    // Arms detection and sends a 0x55 at the given bit period.
    task automatic applyStimulus(input string name, input int period);
        pulseStart();
        sendByte(period, 8'h55);
        waitIdle(name, 200);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst         = 1'b1;
        rx_in       = 1'b1;
        start       = 1'b0;
        cfg_wr      = 1'b0;
        cfg_tx      = 32'hDEAD_BEEF;
        cfg_rx      = 32'h1234_5678;
        modelTx     = 32'd325;
        modelRx     = 32'd20;
        modelLocked = 1'b0;
        modelErr    = 1'b0;

        vecs[0] = '{period: 40,  expTx: 32'd325, expRx: 32'd20, expLocked: 1'b0, expErr: 1'b1};
        vecs[1] = '{period: 160, expTx: 32'd79,  expRx: 32'd4,  expLocked: 1'b1, expErr: 1'b0};
        vecs[2] = '{period: 63,  expTx: 32'd79,  expRx: 32'd4,  expLocked: 1'b0, expErr: 1'b1};
        vecs[3] = '{period: 64,  expTx: 32'd31,  expRx: 32'd1,  expLocked: 1'b1, expErr: 1'b0};
        vecs[4] = '{period: 499, expTx: 32'd248, expRx: 32'd14, expLocked: 1'b1, expErr: 1'b0};
        vecs[5] = '{period: 320, expTx: 32'd159, expRx: 32'd9,  expLocked: 1'b1, expErr: 1'b0};

        $display("[TB] reset values");
        repeat (3) @(posedge clk);
        checkOutput("reset", 32'd325, 32'd20, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        checkOutput("postReset", 32'd325, 32'd20, 1'b0, 1'b0, 1'b0);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].period);
            checkOutput($sformatf("vec%0d", i), vecs[i].expTx, vecs[i].expRx,
                        vecs[i].expLocked, vecs[i].expErr, 1'b0);
            modelTx     = vecs[i].expTx;
            modelRx     = vecs[i].expRx;
            modelLocked = vecs[i].expLocked;
            modelErr    = vecs[i].expErr;
        end

        $display("[TB] timeout after a single edge");
        pulseStart();
        rx_in = 1'b0;
        repeat (TIMEOUT + 2) @(posedge clk);
        checkOutput("timeoutBefore", modelTx, modelRx, 1'b0, 1'b0, 1'b1);
        checkOutput("timeoutAt", modelTx, modelRx, 1'b0, 1'b1, 1'b0);
        rx_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        modelLocked = 1'b0;
        modelErr    = 1'b1;

        $display("[TB] manual load mid-measurement");
        pulseStart();
        fork
            sendByte(200, 8'h55);
            begin
                repeat (2 * 200 + 5) @(posedge clk);
                checkOutput("midMeasure", modelTx, modelRx, 1'b0, 1'b0, 1'b1);
                @(posedge clk);
                #1 cfg_wr = 1'b1;
                cfg_tx = 32'd100;
                cfg_rx = 32'd6;
                @(posedge clk);
                #1 cfg_wr = 1'b0;
                cfg_tx = $urandom;
                cfg_rx = $urandom;
                checkOutput("cfgMid", 32'd100, 32'd6, 1'b1, 1'b0, 1'b0);
            end
        join
        repeat (5) @(posedge clk);
        checkOutput("cfgMidAfter", 32'd100, 32'd6, 1'b1, 1'b0, 1'b0);

        $display("[TB] start and manual load together");
        @(posedge clk);
        #1 start = 1'b1;
        cfg_wr = 1'b1;
        cfg_tx = 32'd77;
        cfg_rx = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        cfg_wr = 1'b0;
        cfg_tx = $urandom;
        cfg_rx = $urandom;
        checkOutput("startCfg", 32'd77, 32'd3, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        sendByte(160, 8'h55);
        repeat (5) @(posedge clk);
        checkOutput("startCfgAfter", 32'd77, 32'd3, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset mid-measurement");
        pulseStart();
        fork
            sendByte(320, 8'h55);
            begin
                repeat (4 * 320 + 20) @(posedge clk);
                #1 rst = 1'b1;
                checkOutput("rstHeld", 32'd325, 32'd20, 1'b0, 1'b0, 1'b0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        checkOutput("rstAfter", 32'd325, 32'd20, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        modelTx = 32'd325;
        modelRx = 32'd20;
        applyStimulus("rstRerun", 320);
        modelMeasure(320);
        checkOutput("rstRerun", modelTx, modelRx, modelLocked, modelErr, 1'b0);

        $display("[TB] random bit periods");
        for (int i = 0; i < 6; i++) begin
            int period;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1 cfg_wr = 1'b1;
                cfg_tx = $urandom_range(0, 1000);
                cfg_rx = $urandom_range(0, 100);
                modelTx     = cfg_tx;
                modelRx     = cfg_rx;
                modelLocked = 1'b1;
                modelErr    = 1'b0;
                @(posedge clk);
                #1 cfg_wr = 1'b0;
                cfg_tx = $urandom;
                cfg_rx = $urandom;
                checkOutput($sformatf("rndCfg%0d", i), modelTx, modelRx, modelLocked, modelErr, 1'b0);
            end
            period = $urandom_range(30, 400);
            applyStimulus($sformatf("rnd%0d", i), period);
            modelMeasure(period);
            checkOutput($sformatf("rnd%0d_p%0d", i, period), modelTx, modelRx, modelLocked, modelErr, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
